spi_eeprom_responder: RTL and testbench
=======================================

// Module: spi_eeprom_responder
// PURPOSE
// - SPI target emulating a 25xx-style serial EEPROM: the far end of the program-fetch
//   initiator. Answers READ (0x03) + 16-bit address with a sequential byte stream.
// - Lets the logic controller run against on-chip/bench-loaded program memory without
//   an external part. The host preloads bytes over a parallel load port.
// PARAMETERS
// - ADDR_W   10   memory address width in bits; DEPTH = 2**ADDR_W bytes
// - SYNC_N   2    synchronizer flops on sck, cs_n and copi
// PORTS
// - clk          in   1       system clock; all logic on posedge clk
// - rst          in   1       synchronous reset, active-high
// - sck          in   1       SPI clock from the initiator (mode 0), asynchronous to clk
// - cs_n         in   1       chip select, active-low, asynchronous
// - copi         in   1       initiator -> target data
// - cipo         out  1       target -> initiator data
// - cipo_oe      out  1       1 while selected (synchronized cs_n low)
// - load_valid   in   1       host byte write strobe
// - load_addr    in   ADDR_W  host write address
// - load_data    in   8       host write data
// - load_ready   out  1       1 when a load is accepted this cycle
// - busy         out  1       1 in any state other than IDLE
// - bytes_read   out  16      saturating count of bytes streamed since reset
// BEHAVIOUR
// - Reset: state IDLE; cipo=0, cipo_oe=0, busy=0, bytes_read=0, load_ready=1,
//   bit counter 0, address 0. Memory contents are NOT cleared.
// - Inputs pass through SYNC_N-flop synchronizers; edges detected on synced sck.
//   Requirement: sck high and low phases >= SYNC_N+1 clk periods each.
// - Mode 0: copi sampled on sck rising edge (MSB first); cipo updated on sck falling edge.
// - FSM: IDLE -> CMD on cs_n falling; CMD 8 bits -> ADDRH (opcode 0x03) else IGNORE;
//   ADDRH 8 bits -> ADDRL 8 bits -> READ. IGNORE holds cipo=0 until cs_n high.
// - Address = {ADDRH,ADDRL}[ADDR_W-1:0]; upper bits discarded.
// - READ: on 24th rising edge tx_shift <= mem[addr], addr <= addr+1; each falling edge
//   cipo <= tx_shift[7], shift left; every 8th rising edge in READ reloads next byte,
//   increments addr and bytes_read (saturates at 0xFFFF).
// - First data bit valid on cipo within SYNC_N+2 clk after the falling edge following
//   the 24th rising edge.
// - addr wraps DEPTH-1 -> 0 silently; stream continues indefinitely.
// - cs_n rising in any state (including mid-byte): -> IDLE next cycle, cipo=0,
//   partial byte discarded, bytes_read not incremented for it.
// - cipo=0 in every state except READ.
// - Load port: load_ready=1 always except the single cycle the FSM reads memory;
//   a load to the address being fetched in that same cycle is stalled one cycle.
// - Simultaneous sck edge and cs_n rising: cs_n wins.
// CONFIGURATION
// - SPI_EEPROM_WRITE_EN defined: adds WREN (0x06) setting a write-enable latch at
//   cs_n rising, and WRITE (0x02) + address + data bytes storing each full byte to
//   mem[addr++] (wraps); WRITE without latch -> IGNORE; latch clears at end of WRITE.
// - Undefined: 0x06 and 0x02 are unknown opcodes -> IGNORE; memory only via load port.
// STRUCTURE
// - Package spi_eeprom_pkg: opcode constants (OP_READ=8'h03, OP_WRITE=8'h02,
//   OP_WREN=8'h06), state enum {IDLE,CMD,ADDRH,ADDRL,READ,WRITE,IGNORE}.
// - Sub-module spi_sync_edge: SYNC_N-flop synchronizer + rise/fall pulse, one per input.
// - Top holds FSM, bit counter, shift registers, memory array, load arbitration.
// TESTING
// - Load mem[0..3]=A5,3C,FF,00; READ addr 0x0000, 32 data clocks -> cipo A5,3C,FF,00.
// - Load mem[0x3FF]=81, mem[0]=7E; READ addr 0x03FF, 16 clocks -> 81 then 7E (wrap).
// - READ addr 0xFC02 with ADDR_W=10 -> byte from mem[0x002] (upper bits dropped).
// - Opcode 0x9F then 16 clocks -> cipo stays 0, busy=1 until cs_n high, then busy=0.
// - cs_n high after 3 bits of 2nd byte -> IDLE, bytes_read=1; new READ works normally.
// - With SPI_EEPROM_WRITE_EN: WREN, WRITE 0x0010 data 5A -> READ 0x0010 returns 5A;
//   WRITE without WREN leaves byte unchanged.

Source files
------------

// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the SPI EEPROM responder.
package spi_eeprom_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDRH,
    ADDRL,
    READ,
    WRITE,
    IGNORE
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, plus a one-cycle toggle
// pulse on any change of the synchronized level (direction is recovered from level).
module spi_sync_edge #(
  parameter int   SYNC_N  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic toggle
);

  logic [SYNC_N-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_N-2:0], din};
    prev_d = sync_q[SYNC_N-1];
    level  = sync_q[SYNC_N-1];
    toggle = sync_q[SYNC_N-1] ^ prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_N{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 target emulating a 25xx serial EEPROM (READ only by default).
// Define SPI_EEPROM_WRITE_EN to add the WREN/WRITE commands.
//
// state  | meaning
// IDLE   | deselected, waiting for cs_n to fall
// CMD    | shifting in the opcode byte
// ADDRH  | shifting in address bits 15:8
// ADDRL  | shifting in address bits 7:0
// READ   | streaming mem[addr++] out on cipo
// WRITE  | storing each received byte to mem[addr++]
// IGNORE | unknown/refused opcode, cipo held 0 until deselect
module spi_eeprom_responder
  import spi_eeprom_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              copi,
  output logic              cipo,
  output logic              cipo_oe,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              busy,
  output logic [15:0]       bytes_read
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic sck_lvl, sck_tgl, cs_lvl, cs_tgl, copi_lvl, copi_tgl;

  spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck), .level(sck_lvl), .toggle(sck_tgl)
  );
  spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_n), .level(cs_lvl), .toggle(cs_tgl)
  );
  spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_lvl), .toggle(copi_tgl)
  );

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  assign sck_rise = sck_tgl & sck_lvl;
  assign sck_fall = sck_tgl & ~sck_lvl;
  assign cs_rise  = cs_tgl & cs_lvl;
  assign cs_fall  = cs_tgl & ~cs_lvl;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        addrh_q, addrh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic              cipo_q, cipo_d;
  logic              cipo_oe_q, cipo_oe_d;
  logic              busy_q, busy_d;
  logic [15:0]       bytes_read_q, bytes_read_d;
`ifdef SPI_EEPROM_WRITE_EN
  logic              wel_q, wel_d;
  logic              wren_q, wren_d;
  logic              wr_cmd_q, wr_cmd_d;
`endif

  logic [7:0]        mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  logic              fetch, spi_we, byte_done;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] addr_new;

  assign rx_byte   = {rx_q[6:0], copi_lvl};
  assign byte_done = sck_rise & (bit_cnt_q == 3'd7);
  assign addr_new  = ADDR_W'({addrh_q, rx_byte});

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    addrh_d      = addrh_q;
    addr_d       = addr_q;
    tx_d         = tx_q;
    cipo_d       = cipo_q;
    bytes_read_d = bytes_read_q;
    fetch        = 1'b0;
    spi_we       = 1'b0;
`ifdef SPI_EEPROM_WRITE_EN
    wel_d        = wel_q;
    wren_d       = wren_q;
    wr_cmd_d     = wr_cmd_q;
`endif
    // Deselect overrides any coincident sck edge.
    if (cs_rise) begin
      state_d = IDLE;
`ifdef SPI_EEPROM_WRITE_EN
      if (wren_q) wel_d = 1'b1;
      if (state_q == WRITE) wel_d = 1'b0;
      wren_d = 1'b0;
`endif
    end else begin
      if (sck_rise && state_q != IDLE && state_q != IGNORE) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_d      = rx_byte;
      end
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end
        CMD: begin
          if (byte_done) begin
            state_d = IGNORE;
            if (rx_byte == OP_READ) state_d = ADDRH;
`ifdef SPI_EEPROM_WRITE_EN
            wr_cmd_d = 1'b0;
            if (rx_byte == OP_WREN) wren_d = 1'b1;
            if (rx_byte == OP_WRITE && wel_q) begin
              state_d  = ADDRH;
              wr_cmd_d = 1'b1;
            end
`endif
          end
        end
        ADDRH: begin
          if (byte_done) begin
            addrh_d = rx_byte;
            state_d = ADDRL;
          end
        end
        ADDRL: begin
          if (byte_done) begin
`ifdef SPI_EEPROM_WRITE_EN
            if (wr_cmd_q) begin
              addr_d  = addr_new;
              state_d = WRITE;
            end else begin
              fetch   = 1'b1;
              tx_d    = mem_q[addr_new];
              addr_d  = addr_new + ADDR_W'(1);
              state_d = READ;
            end
`else
            fetch   = 1'b1;
            tx_d    = mem_q[addr_new];
            addr_d  = addr_new + ADDR_W'(1);
            state_d = READ;
`endif
          end
        end
        READ: begin
          if (byte_done) begin
            fetch        = 1'b1;
            tx_d         = mem_q[addr_q];
            addr_d       = addr_q + ADDR_W'(1);
            bytes_read_d = sat_inc16(bytes_read_q);
          end else if (sck_fall) begin
            cipo_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
`ifdef SPI_EEPROM_WRITE_EN
        WRITE: begin
          if (byte_done) begin
            spi_we = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
    if (state_d != READ) cipo_d = 1'b0;
    busy_d    = (state_d != IDLE);
    cipo_oe_d = ~cs_lvl;
  end

  // The array has one port shared by the FSM and the host; the FSM always wins.
  assign load_ready = ~(fetch | spi_we);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    if (spi_we) begin
      mem_we    = 1'b1;
      mem_waddr = addr_q;
      mem_wdata = rx_byte;
    end else if (load_valid && load_ready) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      addrh_q      <= '0;
      addr_q       <= '0;
      tx_q         <= '0;
      cipo_q       <= 1'b0;
      cipo_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      bytes_read_q <= '0;
`ifdef SPI_EEPROM_WRITE_EN
      wel_q        <= 1'b0;
      wren_q       <= 1'b0;
      wr_cmd_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      addrh_q      <= addrh_d;
      addr_q       <= addr_d;
      tx_q         <= tx_d;
      cipo_q       <= cipo_d;
      cipo_oe_q    <= cipo_oe_d;
      busy_q       <= busy_d;
      bytes_read_q <= bytes_read_d;
`ifdef SPI_EEPROM_WRITE_EN
      wel_q        <= wel_d;
      wren_q       <= wren_d;
      wr_cmd_q     <= wr_cmd_d;
`endif
    end
  end

  assign cipo       = cipo_q;
  assign cipo_oe    = cipo_oe_q;
  assign busy       = busy_q;
  assign bytes_read = bytes_read_q;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed bench for spi_eeprom_responder: bit-banged SPI initiator plus host load port.
module tb_spi_eeprom_responder;

  localparam int ADDR_W = 10;
  localparam int SYNC_N = 2;
  localparam int H      = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              sck, cs_n, copi;
  logic              cipo, cipo_oe;
  logic              load_valid, load_ready, busy;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic [15:0]       bytes_read;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;

  always #5 clk = ~clk;

  spi_eeprom_responder #(.ADDR_W(ADDR_W), .SYNC_N(SYNC_N)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .busy(busy), .bytes_read(bytes_read)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic spi_start();
    cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic spi_stop();
    wait_clk(H);
    cs_n = 1'b1;
    wait_clk(H);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      copi = tx[i];
      wait_clk(H);
      rx[i] = cipo;
      sck = 1'b1;
      wait_clk(H);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic read_cmd(input logic [15:0] a, output logic [7:0] hdr_or);
    logic [7:0] r0, r1, r2;
    spi_byte(8'h03, r0);
    spi_byte(a[15:8], r1);
    spi_byte(a[7:0], r2);
    hdr_or = r0 | r1 | r2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    if (cipo !== 1'b0) begin n_fail++; $display("FAIL reset_cipo: got %b want 0", cipo); end
    n_checks++;
    if (cipo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_cipo_oe: got %b want 0", cipo_oe); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (bytes_read !== 16'd0) begin n_fail++; $display("FAIL reset_bytes_read: got %0d want 0", bytes_read); end
    n_checks++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    n_checks++;
  endtask

  task automatic test_read_basic();
    logic [7:0] exp_d [4];
    logic [7:0] hdr, r;
    exp_d[0] = 8'hA5; exp_d[1] = 8'h3C; exp_d[2] = 8'hFF; exp_d[3] = 8'h00;
    for (int i = 0; i < 4; i++) load_byte(ADDR_W'(i), exp_d[i]);
    spi_start();
    if (cipo_oe !== 1'b1) begin n_fail++; $display("FAIL basic_cipo_oe: got %b want 1", cipo_oe); end
    n_checks++;
    read_cmd(16'h0000, hdr);
    if (hdr !== 8'h00) begin n_fail++; $display("FAIL basic_hdr_cipo: got %h want 00", hdr); end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, r);
      if (r !== exp_d[i]) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", i, r, exp_d[i]); end
      n_checks++;
    end
    exp_br += 4;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_sel: got %b want 1", busy); end
    n_checks++;
    spi_stop();
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_desel: got %b want 0", busy); end
    n_checks++;
    if (cipo !== 1'b0 || cipo_oe !== 1'b0) begin
      n_fail++; $display("FAIL basic_cipo_desel: got %b/%b want 0/0", cipo, cipo_oe);
    end
    n_checks++;
    if (bytes_read !== 16'(exp_br)) begin n_fail++; $display("FAIL basic_bytes_read: got %0d want %0d", bytes_read, exp_br); end
    n_checks++;
  endtask

  task automatic test_wrap();
    logic [7:0] hdr, r0, r1;
    load_byte(10'h3FF, 8'h81);
    load_byte(10'h000, 8'h7E);
    spi_start();
    read_cmd(16'h03FF, hdr);
    spi_byte(8'h00, r0);
    spi_byte(8'h00, r1);
    spi_stop();
    exp_br += 2;
    if (r0 !== 8'h81) begin n_fail++; $display("FAIL wrap_last: got %h want 81", r0); end
    n_checks++;
    if (r1 !== 8'h7E) begin n_fail++; $display("FAIL wrap_first: got %h want 7e", r1); end
    n_checks++;
    if (bytes_read !== 16'(exp_br)) begin n_fail++; $display("FAIL wrap_bytes_read: got %0d want %0d", bytes_read, exp_br); end
    n_checks++;
  endtask

  task automatic test_addr_trunc();
    logic [7:0] hdr, r;
    load_byte(10'h002, 8'hC3);
    spi_start();
    read_cmd(16'hFC02, hdr);
    spi_byte(8'h00, r);
    spi_stop();
    exp_br += 1;
    if (r !== 8'hC3) begin n_fail++; $display("FAIL trunc_data: got %h want c3", r); end
    n_checks++;
  endtask

  task automatic test_unknown_opcode();
    logic [7:0] r0, r1, r2;
    spi_start();
    spi_byte(8'h9F, r0);
    spi_byte(8'h00, r1);
    spi_byte(8'h00, r2);
    if ((r0 | r1 | r2) !== 8'h00) begin n_fail++; $display("FAIL unk_cipo: got %h want 00", r0 | r1 | r2); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL unk_busy_sel: got %b want 1", busy); end
    n_checks++;
    spi_stop();
    if (busy !== 1'b0) begin n_fail++; $display("FAIL unk_busy_desel: got %b want 0", busy); end
    n_checks++;
    if (bytes_read !== 16'(exp_br)) begin n_fail++; $display("FAIL unk_bytes_read: got %0d want %0d", bytes_read, exp_br); end
    n_checks++;
  endtask

  task automatic test_abort();
    logic [7:0] hdr, r0, rp, r1;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    exp_br = 0;
    spi_start();
    read_cmd(16'h0000, hdr);
    spi_byte(8'h00, r0);
    spi_bits(8'h00, 3, rp);
    spi_stop();
    exp_br += 1;
    if (r0 !== 8'h7E) begin n_fail++; $display("FAIL abort_first: got %h want 7e", r0); end
    n_checks++;
    if (rp !== 8'h20) begin n_fail++; $display("FAIL abort_partial: got %h want 20", rp); end
    n_checks++;
    if (bytes_read !== 16'(exp_br)) begin n_fail++; $display("FAIL abort_bytes_read: got %0d want %0d", bytes_read, exp_br); end
    n_checks++;
    if (busy !== 1'b0 || cipo !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy %b cipo %b want 0 0", busy, cipo); end
    n_checks++;
    spi_start();
    read_cmd(16'h0001, hdr);
    spi_byte(8'h00, r1);
    spi_stop();
    exp_br += 1;
    if (r1 !== 8'h3C) begin n_fail++; $display("FAIL abort_reread: got %h want 3c", r1); end
    n_checks++;
    if (bytes_read !== 16'(exp_br)) begin n_fail++; $display("FAIL abort_bytes_read2: got %0d want %0d", bytes_read, exp_br); end
    n_checks++;
  endtask

  task automatic test_load_stall();
    logic [7:0] hdr, r;
    int stall_cnt;
    bit mon_en;
    stall_cnt = 0;
    mon_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = 10'h200;
    load_data  = 8'h99;
    fork
      begin
        spi_start();
        read_cmd(16'h0300, hdr);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        spi_stop();
        mon_en = 1'b0;
      end
      begin
        for (int c = 0; c < 5000 && mon_en; c++) begin
          @(negedge clk);
          if (!load_ready) stall_cnt++;
        end
      end
    join
    load_valid = 1'b0;
    exp_br += 2;
    if (stall_cnt != 3) begin n_fail++; $display("FAIL stall_cycles: got %0d want 3", stall_cnt); end
    n_checks++;
    spi_start();
    read_cmd(16'h0200, hdr);
    spi_byte(8'h00, r);
    spi_stop();
    exp_br += 1;
    if (r !== 8'h99) begin n_fail++; $display("FAIL stall_load_data: got %h want 99", r); end
    n_checks++;
  endtask

  task automatic test_write_opcodes();
    logic [7:0] r, hdr, exp10;
    load_byte(10'h010, 8'h44);
    load_byte(10'h011, 8'h22);
`ifdef SPI_EEPROM_WRITE_EN
    exp10 = 8'h5A;
`else
    exp10 = 8'h44;
`endif
    spi_start(); spi_byte(8'h06, r); spi_stop();
    spi_start();
    spi_byte(8'h02, r); spi_byte(8'h00, r); spi_byte(8'h10, r); spi_byte(8'h5A, r);
    spi_stop();
    spi_start(); read_cmd(16'h0010, hdr); spi_byte(8'h00, r); spi_stop();
    exp_br += 1;
    if (r !== exp10) begin n_fail++; $display("FAIL wr_enabled_byte: got %h want %h", r, exp10); end
    n_checks++;
    spi_start();
    spi_byte(8'h02, r); spi_byte(8'h00, r); spi_byte(8'h11, r); spi_byte(8'h77, r);
    spi_stop();
    spi_start(); read_cmd(16'h0011, hdr); spi_byte(8'h00, r); spi_stop();
    exp_br += 1;
    if (r !== 8'h22) begin n_fail++; $display("FAIL wr_no_wren_byte: got %h want 22", r); end
    n_checks++;
    if (bytes_read !== 16'(exp_br)) begin n_fail++; $display("FAIL wr_bytes_read: got %0d want %0d", bytes_read, exp_br); end
    n_checks++;
  endtask

  initial begin
    rst        = 1'b1;
    sck        = 1'b0;
    cs_n       = 1'b1;
    copi       = 1'b0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    test_reset();
    test_read_basic();
    test_wrap();
    test_addr_trunc();
    test_unknown_opcode();
    test_abort();
    test_load_stall();
    test_write_opcodes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
